// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings for the forwarding and hazard controller
// Forwarding-select codes, MCU scoreboard states and stall-cause bit positions.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_t;

    localparam int CAUSE_LOAD_USE  = 0;
    localparam int CAUSE_MC_RAW    = 1;
    localparam int CAUSE_MC_STRUCT = 2;
    localparam int CAUSE_W         = 3;

    // Down-counter width; MCU latency is at most 15 cycles.
    localparam int MC_CNT_W = 4;

endpackage

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - forwarding mux select for one EX-stage source operand
// Ports:
//   rs               EX-stage source register of this operand
//   ex_mem_regwrite  EX/MEM instruction writes a register
//   ex_mem_rd        EX/MEM destination
//   mem_wb_regwrite  MEM/WB instruction writes a register
//   mem_wb_rd        MEM/WB destination
//   sel              FWD_RF / FWD_MEM / FWD_WB
module fwd_select
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic              ex_mem_regwrite,
    input  logic [REG_AW-1:0] ex_mem_rd,
    input  logic              mem_wb_regwrite,
    input  logic [REG_AW-1:0] mem_wb_rd,
    output logic [1:0]        sel
);

    // The younger EX/MEM result wins over MEM/WB; x0 is hardwired zero and never forwarded.
    always_comb begin
        sel = FWD_RF;
        if (ex_mem_regwrite && (ex_mem_rd != '0) && (rs == ex_mem_rd)) begin
            sel = FWD_MEM;
        end else if (mem_wb_regwrite && (mem_wb_rd != '0) && (rs == mem_wb_rd)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding, stall detection and MCU scoreboard
// Ports:
//   clk, rst_n                     rising-edge clock, synchronous active-low reset
//   ex_rs                          EX source regs, operand i at [i*REG_AW +: REG_AW]
//   id_rs, id_rs_valid, id_is_mc   ID source regs, read enables, ID op uses the MCU
//   ID_EX_MemRead, ID_EX_rd        load in EX and its destination
//   EX_MEM_*, MEM_WB_*             writeback info of the later stages
//   mc_issue, mc_issue_rd          MCU op leaving EX this cycle and its destination
//   fwd_sel                        per-operand forwarding select, 2 bits each
//   stall, stall_cause             stall request and {mc_struct, mc_raw, load_use}
//   mc_busy, mc_done, mc_rd        MCU scoreboard state
//   stall_cnt                      saturating count of stalled cycles
//   err_overlap                    sticky: MCU issue seen while busy
module fwd_hazard_unit
    import hazard_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = 5,
    parameter int MC_LAT  = 4,
    parameter int PERF_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC*REG_AW-1:0] ex_rs,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]        id_rs_valid,
    input  logic                      id_is_mc,
    input  logic                      ID_EX_MemRead,
    input  logic [REG_AW-1:0]         ID_EX_rd,
    input  logic                      EX_MEM_RegWrite,
    input  logic [REG_AW-1:0]         EX_MEM_rd,
    input  logic                      MEM_WB_RegWrite,
    input  logic [REG_AW-1:0]         MEM_WB_rd,
    input  logic                      mc_issue,
    input  logic [REG_AW-1:0]         mc_issue_rd,
    output logic [NUM_SRC*2-1:0]      fwd_sel,
    output logic                      stall,
    output logic [2:0]                stall_cause,
    output logic                      mc_busy,
    output logic                      mc_done,
    output logic [REG_AW-1:0]         mc_rd,
    output logic [PERF_W-1:0]         stall_cnt,
    output logic                      err_overlap
);

    mc_state_t             state;
    logic [MC_CNT_W-1:0]   cnt;

    // EX-stage forwarding, one selector per operand.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
        fwd_select #(.REG_AW(REG_AW)) u_fwd_select (
            .rs              (ex_rs[i*REG_AW +: REG_AW]),
            .ex_mem_regwrite (EX_MEM_RegWrite),
            .ex_mem_rd       (EX_MEM_rd),
            .mem_wb_regwrite (MEM_WB_RegWrite),
            .mem_wb_rd       (MEM_WB_rd),
            .sel             (fwd_sel[i*2 +: 2])
        );
    end

    assign mc_busy = (state == MC_BUSY);
    assign mc_done = mc_busy && (cnt == '0);

    // ID-stage hazard detection. An MCU op issuing from IDLE is already in EX,
    // so only the registered busy state can stall ID.
    always_comb begin
        logic              load_use;
        logic              mc_raw;
        logic              match;
        logic [REG_AW-1:0] rs;
        load_use = 1'b0;
        mc_raw   = 1'b0;
        match    = 1'b0;
        rs       = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            rs    = id_rs[i*REG_AW +: REG_AW];
            match = id_rs_valid[i] && (rs != '0);
            if (match && (rs == ID_EX_rd)) begin
                load_use = 1'b1;
            end
            if (match && (rs == mc_rd)) begin
                mc_raw = 1'b1;
            end
        end
        stall_cause                  = '0;
        stall_cause[CAUSE_LOAD_USE]  = load_use && ID_EX_MemRead && (ID_EX_rd != '0);
        // Still asserted on the done cycle: the result is not in the regfile yet.
        stall_cause[CAUSE_MC_RAW]    = mc_raw && mc_busy && (mc_rd != '0);
        stall_cause[CAUSE_MC_STRUCT] = mc_busy && id_is_mc;
        stall                        = |stall_cause;
    end

    // MCU scoreboard. A second issue while busy is flagged and dropped so the
    // original op still completes with its own destination.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= MC_IDLE;
            cnt         <= '0;
            mc_rd       <= '0;
            err_overlap <= 1'b0;
        end else begin
            case (state)
                MC_IDLE: begin
                    if (mc_issue) begin
                        state <= MC_BUSY;
                        cnt   <= MC_CNT_W'(MC_LAT - 1);
                        mc_rd <= mc_issue_rd;
                    end
                end
                MC_BUSY: begin
                    if (mc_issue) begin
                        err_overlap <= 1'b1;
                    end
                    if (cnt == '0) begin
                        state <= MC_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= MC_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - self-checking bench for fwd_hazard_unit
module tb_fwd_hazard_unit;

    localparam int NUM_SRC = 2;
    localparam int REG_AW  = 5;
    localparam int MC_LAT  = 4;
    localparam int PERF_W  = 4;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_SRC*REG_AW-1:0] ex_rs;
    logic [NUM_SRC*REG_AW-1:0] id_rs;
    logic [NUM_SRC-1:0]        id_rs_valid;
    logic                      id_is_mc;
    logic                      ID_EX_MemRead;
    logic [REG_AW-1:0]         ID_EX_rd;
    logic                      EX_MEM_RegWrite;
    logic [REG_AW-1:0]         EX_MEM_rd;
    logic                      MEM_WB_RegWrite;
    logic [REG_AW-1:0]         MEM_WB_rd;
    logic                      mc_issue;
    logic [REG_AW-1:0]         mc_issue_rd;
    logic [NUM_SRC*2-1:0]      fwd_sel;
    logic                      stall;
    logic [2:0]                stall_cause;
    logic                      mc_busy;
    logic                      mc_done;
    logic [REG_AW-1:0]         mc_rd;
    logic [PERF_W-1:0]         stall_cnt;
    logic                      err_overlap;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(
        .NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .MC_LAT(MC_LAT), .PERF_W(PERF_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ex_rs           (ex_rs),
        .id_rs           (id_rs),
        .id_rs_valid     (id_rs_valid),
        .id_is_mc        (id_is_mc),
        .ID_EX_MemRead   (ID_EX_MemRead),
        .ID_EX_rd        (ID_EX_rd),
        .EX_MEM_RegWrite (EX_MEM_RegWrite),
        .EX_MEM_rd       (EX_MEM_rd),
        .MEM_WB_RegWrite (MEM_WB_RegWrite),
        .MEM_WB_rd       (MEM_WB_rd),
        .mc_issue        (mc_issue),
        .mc_issue_rd     (mc_issue_rd),
        .fwd_sel         (fwd_sel),
        .stall           (stall),
        .stall_cause     (stall_cause),
        .mc_busy         (mc_busy),
        .mc_done         (mc_done),
        .mc_rd           (mc_rd),
        .stall_cnt       (stall_cnt),
        .err_overlap     (err_overlap)
    );

    typedef struct {
        string        name;
        logic [4:0]   ex0, ex1;
        logic         exmem_we;
        logic [4:0]   exmem_rd;
        logic         memwb_we;
        logic [4:0]   memwb_rd;
        logic [4:0]   id0, id1;
        logic [1:0]   valid;
        logic         memread;
        logic [4:0]   idex_rd;
        logic         is_mc;
        logic [3:0]   exp_fwd;
        logic         exp_stall;
        logic [2:0]   exp_cause;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_rs = '0; id_rs = '0; id_rs_valid = '0; id_is_mc = 1'b0;
        ID_EX_MemRead = 1'b0; ID_EX_rd = '0;
        EX_MEM_RegWrite = 1'b0; EX_MEM_rd = '0;
        MEM_WB_RegWrite = 1'b0; MEM_WB_rd = '0;
        mc_issue = 1'b0; mc_issue_rd = '0;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // name, ex0, ex1, exmem_we, exmem_rd, memwb_we, memwb_rd, id0, id1, valid, memread, idex_rd, is_mc, fwd, stall, cause
        vecs[0] = '{"fwd_prio_mem", 5, 3, 1, 5, 1, 5, 0, 0, 2'b00, 0, 0, 0, 4'b0010, 0, 3'b000};
        vecs[1] = '{"fwd_wb",       5, 3, 0, 5, 1, 5, 0, 0, 2'b00, 0, 0, 0, 4'b0001, 0, 3'b000};
        vecs[2] = '{"fwd_x0",       0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 4'b0000, 0, 3'b000};
        vecs[3] = '{"fwd_mixed",    4, 6, 1, 6, 1, 4, 0, 0, 2'b00, 0, 0, 0, 4'b1001, 0, 3'b000};
        vecs[4] = '{"lu_rd0",       0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 1, 0, 0, 4'b0000, 0, 3'b000};
        vecs[5] = '{"lu_src1",      0, 0, 0, 0, 0, 0, 0, 7, 2'b10, 1, 7, 0, 4'b0000, 1, 3'b001};
        vecs[6] = '{"lu_invalid",   0, 0, 0, 0, 0, 0, 0, 7, 2'b01, 1, 7, 0, 4'b0000, 0, 3'b000};
        vecs[7] = '{"mc_idle",      0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 4'b0000, 0, 3'b000};
        vecs[8] = '{"no_load",      0, 0, 0, 0, 0, 0, 7, 7, 2'b11, 0, 7, 0, 4'b0000, 0, 3'b000};
        vecs[9] = '{"lu_src0",      9, 0, 0, 0, 1, 9, 7, 0, 2'b01, 1, 7, 0, 4'b0001, 1, 3'b001};

        rst_n = 1'b0;
        idle_inputs();
        do_reset();
        @(negedge clk);
        chk("rst_busy", 32'(mc_busy), 0);
        chk("rst_done", 32'(mc_done), 0);
        chk("rst_mc_rd", 32'(mc_rd), 0);
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        chk("rst_err", 32'(err_overlap), 0);

        // Combinational vectors, scoreboard idle.
        for (int v = 0; v < 10; v++) begin
            tick();
            ex_rs           = {vecs[v].ex1, vecs[v].ex0};
            EX_MEM_RegWrite = vecs[v].exmem_we;
            EX_MEM_rd       = vecs[v].exmem_rd;
            MEM_WB_RegWrite = vecs[v].memwb_we;
            MEM_WB_rd       = vecs[v].memwb_rd;
            id_rs           = {vecs[v].id1, vecs[v].id0};
            id_rs_valid     = vecs[v].valid;
            ID_EX_MemRead   = vecs[v].memread;
            ID_EX_rd        = vecs[v].idex_rd;
            id_is_mc        = vecs[v].is_mc;
            @(negedge clk);
            chk({vecs[v].name, "_fwd"},   32'(fwd_sel),     32'(vecs[v].exp_fwd));
            chk({vecs[v].name, "_stall"}, 32'(stall),       32'(vecs[v].exp_stall));
            chk({vecs[v].name, "_cause"}, 32'(stall_cause), 32'(vecs[v].exp_cause));
        end

        // MCU RAW: issue at cycle 0 with rd=9, ID reads x9.
        idle_inputs();
        do_reset();
        id_rs = {5'd0, 5'd9};
        id_rs_valid = 2'b01;
        mc_issue = 1'b1;
        mc_issue_rd = 5'd9;
        @(negedge clk);
        chk("raw_c0_busy", 32'(mc_busy), 0);
        chk("raw_c0_stall", 32'(stall), 0);
        for (int c = 1; c <= 5; c++) begin
            tick();
            mc_issue = 1'b0;
            mc_issue_rd = '0;
            @(negedge clk);
            chk($sformatf("raw_c%0d_busy", c),  32'(mc_busy),     (c <= 4) ? 1 : 0);
            chk($sformatf("raw_c%0d_done", c),  32'(mc_done),     (c == 4) ? 1 : 0);
            chk($sformatf("raw_c%0d_cause", c), 32'(stall_cause), (c <= 4) ? 3'b010 : 3'b000);
            if (c <= 4) chk($sformatf("raw_c%0d_rd", c), 32'(mc_rd), 9);
        end
        chk("raw_stall_cnt", 32'(stall_cnt), 4);

        // Overlap: second issue at cycle 2; structural stall probed at cycle 1.
        idle_inputs();
        do_reset();
        mc_issue = 1'b1;
        mc_issue_rd = 5'd9;
        for (int c = 1; c <= 5; c++) begin
            tick();
            mc_issue    = (c == 2);
            mc_issue_rd = (c == 2) ? 5'd12 : 5'd0;
            id_is_mc    = (c == 1);
            @(negedge clk);
            if (c == 1) chk("ovl_struct", 32'(stall_cause), 3'b100);
            chk($sformatf("ovl_c%0d_err", c),  32'(err_overlap), (c >= 3) ? 1 : 0);
            chk($sformatf("ovl_c%0d_done", c), 32'(mc_done),     (c == 4) ? 1 : 0);
            if (c == 4) chk("ovl_done_rd", 32'(mc_rd), 9);
        end

        // Reset mid-op: rst_n low during cycle 2.
        idle_inputs();
        do_reset();
        id_rs = {5'd0, 5'd9};
        id_rs_valid = 2'b01;
        mc_issue = 1'b1;
        mc_issue_rd = 5'd9;
        tick();
        mc_issue = 1'b0;
        tick();
        @(negedge clk);
        chk("mid_c2_cnt", 32'(stall_cnt), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_c3_busy", 32'(mc_busy), 0);
        chk("mid_c3_cnt", 32'(stall_cnt), 0);
        for (int c = 4; c <= 6; c++) begin
            tick();
            @(negedge clk);
            chk($sformatf("mid_c%0d_done", c), 32'(mc_done), 0);
        end

        // Saturation: 20 load-use stall cycles on a 4-bit counter.
        idle_inputs();
        do_reset();
        ID_EX_MemRead = 1'b1;
        ID_EX_rd = 5'd3;
        id_rs = {5'd3, 5'd0};
        id_rs_valid = 2'b10;
        for (int c = 0; c < 20; c++) tick();
        @(negedge clk);
        chk("sat_cnt", 32'(stall_cnt), 15);
        tick();
        @(negedge clk);
        chk("sat_hold", 32'(stall_cnt), 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
